oled_pixel_feeder: RTL and testbench
====================================

OLED_PIXEL_FEEDER -- requirements
Module: oled_pixel_feeder

Interface
REQ-001 Parameter DEPTH, default 16, gives the command FIFO depth in entries and SHALL be a power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, gives the clk cycles allowed from strobe assertion to drv_valid (used only with timeout compiled in).
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 push  in  1  one-cycle write request from the CPU/bus side.
REQ-006 push_raw  in  1  1 = raw 8-bit transfer, 0 = set-pixel command.
REQ-007 push_x_dc / push_y_data  in  8 each  x coordinate (raw: bit0 = D/C, bit1 = CS toggle) / y coordinate (raw: data byte).
REQ-008 push_rgb  in  16  RGB565 pixel colour (ignored in raw mode).
REQ-009 full, empty  out  1 each  FIFO status.
REQ-010 level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 busy  out  1  high while the FSM is not IDLE.
REQ-012 overflow  out  1  sticky: a push was dropped.
REQ-013 timeout_err  out  1  sticky: the driver missed the deadline.
REQ-014 clr_err  in  1  synchronous clear of overflow and timeout_err.
REQ-015 strobe, setpixel_raw8tx  out  1 each  to the display driver.
REQ-016 x_dc, y_data  out  8 each; rgb  out  16  to the display driver.
REQ-017 drv_ready, drv_valid  in  1 each  from the display driver; drv_valid is a one-cycle completion pulse.

Function
REQ-018 A FIFO entry SHALL be {raw, x_dc, y_data, rgb}, 33 bits.
REQ-019 A push with full=0 SHALL write the entry at the tail; level increments the next cycle.
REQ-020 A push with full=1 SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-021 A simultaneous push and pop with level between 1 and DEPTH-1 SHALL leave level unchanged.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 The FSM SHALL have three states:
- IDLE: when empty=0 and drv_ready=1, load the head entry into the output registers, pop it, and go to STROBE.
- STROBE: hold strobe=1 until drv_ready=0, then drive strobe=0 and go to WAIT.
- WAIT: on drv_valid=1, go to IDLE.
REQ-024 x_dc, y_data, rgb and setpixel_raw8tx SHALL remain stable from the load cycle until the cycle after drv_valid, because the driver samples them throughout the transfer.
REQ-025 The earliest strobe assertion SHALL be one cycle after the load decision, so the best-case latency from push into an empty FIFO to strobe is 2 cycles.
REQ-026 Strobe SHALL be a registered level; back-to-back commands SHALL have at least one strobe-low cycle between them.
REQ-027 drv_valid received outside WAIT SHALL be ignored.
REQ-028 clr_err and a same-cycle error event together SHALL leave the flag set.

Reset
REQ-029 Asserting resetn low SHALL immediately force: FSM to IDLE, pointers and level to 0, empty=1, full=0, busy=0, strobe=0, setpixel_raw8tx=0, x_dc=0, y_data=0, rgb=0, overflow=0, timeout_err=0.
REQ-030 Reset during STROBE or WAIT SHALL abandon the in-flight command and discard FIFO contents.

Configuration
REQ-031 With macro OLED_PIXEL_FEEDER_TIMEOUT_EN defined, a counter SHALL start at strobe assertion; at TIMEOUT_CYCLES without drv_valid the FSM SHALL drive strobe=0, set timeout_err and return to IDLE.
REQ-032 Without OLED_PIXEL_FEEDER_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-033 Shared package oled_pkg SHALL hold the entry field widths, the FSM state encoding and the RGB565 field positions.
REQ-034 The FIFO SHALL be a sub-module sync_fifo parameterised by width and depth; the FSM and error flags live in the top module.

Verification
REQ-035 Pixel path: push raw=0, x=0x10, y=0x20, rgb=0xF800 with a driver model -> strobe high 2 cycles later, outputs held until valid, busy then 0, level 0.
REQ-036 Raw path: push raw=1, x_dc=0x01, y_data=0xA5 -> setpixel_raw8tx=0, y_data=0xA5 held until drv_valid.
REQ-037 Overflow: DEPTH+1 pushes with drv_ready=0 -> level=DEPTH, full=1, overflow=1, last entry dropped; clr_err -> overflow=0.
REQ-038 Ordering: 5 queued pixels with random driver delays -> 5 strobes in push order, each separated by at least one low cycle.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES=32): drv_valid withheld -> timeout_err=1 at cycle 32, strobe=0, next entry issued.
REQ-040 Reset mid-WAIT with 3 entries queued -> all outputs at reset values, empty=1, and the late drv_valid is ignored.

Source files
------------

// File: rtl/oled_pixel_feeder_pkg.sv
// oled_pkg: shared types for the OLED pixel feeder.
//   - entry field widths and the packed FIFO entry layout {raw, x_dc, y_data, rgb}
//   - RGB565 field positions (red [15:11], green [10:5], blue [4:0])
//   - FSM state encoding
//   - pack_entry(): builds a FIFO entry from the push-side fields
package oled_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 8;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int unsigned RGB_W = $bits(rgb565_t);

    typedef struct packed {
        logic           raw;
        logic [X_W-1:0] x_dc;
        logic [Y_W-1:0] y_data;
        rgb565_t        rgb;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    function automatic entry_t pack_entry(
        input logic             raw,
        input logic [X_W-1:0]   x,
        input logic [Y_W-1:0]   y,
        input logic [RGB_W-1:0] rgb
    );
        entry_t e;
        e.raw    = raw;
        e.x_dc   = x;
        e.y_data = y;
        e.rgb    = rgb;
        return e;
    endfunction

endpackage

// File: rtl/oled_pixel_feeder_sync_fifo.sv
// sync_fifo: single-clock FIFO, WIDTH bits x DEPTH entries (DEPTH a power of two).
// Ports:
//   clk, resetn          clock, asynchronous active-low reset (empties the FIFO)
//   wr_en_i, wr_data_i   write request; ignored while full
//   rd_en_i, rd_data_o   pop request; rd_data_o always shows the head entry
//   full_o, empty_o      status
//   level_o              occupancy, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_wr, do_rd;

    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/oled_pixel_feeder.sv
// oled_pixel_feeder: queues set-pixel / raw-byte commands and hands them one at a
// time to an OLED display driver with a strobe / ready / valid handshake.
// Optional feature: define OLED_PIXEL_FEEDER_TIMEOUT_EN to abort a transfer that
// gets no drv_valid within TIMEOUT_CYCLES of strobe assertion (sets timeout_err).
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   push, push_raw, push_x_dc,
//   push_y_data, push_rgb             command write side
//   full, empty, level                FIFO status
//   busy                              FSM not idle
//   overflow, timeout_err, clr_err    sticky error flags and their clear
//   strobe, setpixel_raw8tx,
//   x_dc, y_data, rgb                 command to the driver (setpixel_raw8tx = 1 for pixel)
//   drv_ready, drv_valid              driver handshake (drv_valid is a 1-cycle pulse)
module oled_pixel_feeder
    import oled_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   push_raw,
    input  logic [X_W-1:0]         push_x_dc,
    input  logic [Y_W-1:0]         push_y_data,
    input  logic [RGB_W-1:0]       push_rgb,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   timeout_err,
    input  logic                   clr_err,
    output logic                   strobe,
    output logic                   setpixel_raw8tx,
    output logic [X_W-1:0]         x_dc,
    output logic [Y_W-1:0]         y_data,
    output logic [RGB_W-1:0]       rgb,
    input  logic                   drv_ready,
    input  logic                   drv_valid
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("oled_pixel_feeder: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("oled_pixel_feeder: TIMEOUT_CYCLES must be >= 1");
    end

    state_t         state_q, state_d;
    entry_t         head;
    logic           load;
    logic           strobe_q, strobe_d;
    logic           setpix_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic [RGB_W-1:0] rgb_q;
    logic           ovf_q;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en_i   (push),
        .wr_data_i (pack_entry(push_raw, push_x_dc, push_y_data, push_rgb)),
        .rd_en_i   (load),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (level)
    );

`ifdef OLED_PIXEL_FEEDER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q;
    logic          tmo_q;
    logic          tmo_evt;
`endif

    always_comb begin
        state_d  = state_q;
        strobe_d = strobe_q;
        load     = 1'b0;
`ifdef OLED_PIXEL_FEEDER_TIMEOUT_EN
        tmo_evt  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && drv_ready) begin
                    load     = 1'b1;
                    strobe_d = 1'b1;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (!drv_ready) begin
                    strobe_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (drv_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                strobe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
`ifdef OLED_PIXEL_FEEDER_TIMEOUT_EN
        // Counter is 0 in the first strobe-high cycle, so this fires
        // TIMEOUT_CYCLES edges after strobe rose; a completing drv_valid wins.
        if (state_q != ST_IDLE && tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1) &&
            !(state_q == ST_WAIT && drv_valid)) begin
            tmo_evt  = 1'b1;
            strobe_d = 1'b0;
            state_d  = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
        end
    end

    // Output fields change only on a load, so they stay put through WAIT and
    // the cycle after drv_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            setpix_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            rgb_q    <= '0;
        end else if (load) begin
            setpix_q <= !head.raw;
            x_q      <= head.x_dc;
            y_q      <= head.y_data;
            rgb_q    <= head.rgb;
        end
    end

    // A same-cycle error event outranks clr_err.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !clr_err) || (push && full);
        end
    end

`ifdef OLED_PIXEL_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (load) begin
                tmo_cnt_q <= '0;
            end else if (state_q != ST_IDLE) begin
                tmo_cnt_q <= tmo_cnt_q + CW'(1);
            end
            tmo_q <= (tmo_q && !clr_err) || tmo_evt;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy            = (state_q != ST_IDLE);
    assign strobe          = strobe_q;
    assign setpixel_raw8tx = setpix_q;
    assign x_dc            = x_q;
    assign y_data          = y_q;
    assign rgb             = rgb_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_oled_pixel_feeder.sv
`timescale 1ns/1ps
module tb_oled_pixel_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 32;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          push;
    logic          push_raw;
    logic [7:0]    push_x_dc;
    logic [7:0]    push_y_data;
    logic [15:0]   push_rgb;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          busy;
    logic          overflow;
    logic          timeout_err;
    logic          clr_err;
    logic          strobe;
    logic          setpixel_raw8tx;
    logic [7:0]    x_dc;
    logic [7:0]    y_data;
    logic [15:0]   rgb;
    logic          drv_ready;
    logic          drv_valid;

    typedef struct {
        logic        raw;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] rgb;
    } cmd_t;

    cmd_t model_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [43:0] RESET_VEC = {1'b1, 1'b0, LW'(0), 1'b0, 1'b0, 1'b0,
                                         8'h00, 8'h00, 16'h0000, 1'b0, 1'b0};

    always #5 clk = ~clk;

    oled_pixel_feeder #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .push            (push),
        .push_raw        (push_raw),
        .push_x_dc       (push_x_dc),
        .push_y_data     (push_y_data),
        .push_rgb        (push_rgb),
        .full            (full),
        .empty           (empty),
        .level           (level),
        .busy            (busy),
        .overflow        (overflow),
        .timeout_err     (timeout_err),
        .clr_err         (clr_err),
        .strobe          (strobe),
        .setpixel_raw8tx (setpixel_raw8tx),
        .x_dc            (x_dc),
        .y_data          (y_data),
        .rgb             (rgb),
        .drv_ready       (drv_ready),
        .drv_valid       (drv_valid)
    );

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.raw = 1'($urandom_range(0, 1));
        c.x   = 8'($urandom);
        c.y   = 8'($urandom);
        c.rgb = 16'($urandom);
        return c;
    endfunction

    function automatic logic [32:0] expect_out(input cmd_t c);
        return {~c.raw, c.x, c.y, c.rgb};
    endfunction

    task automatic drive_push(input cmd_t c);
        push        = 1'b1;
        push_raw    = c.raw;
        push_x_dc   = c.x;
        push_y_data = c.y;
        push_rgb    = c.rgb;
    endtask

    task automatic test_reset();
        cmd_t c;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        drv_ready = 1'b1;
        c = rand_cmd();
        drive_push(c);
        @(negedge clk);
        push = 1'b0;
        @(negedge clk);
        n_tests++;
        if (strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_strobe: got %b want 1", strobe);
        end
        #3 resetn = 1'b0;
        #1;
        n_tests++;
        if ({empty, full, level, busy, strobe, setpixel_raw8tx, x_dc, y_data, rgb,
             overflow, timeout_err} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h",
                     {empty, full, level, busy, strobe, setpixel_raw8tx, x_dc, y_data, rgb,
                      overflow, timeout_err}, RESET_VEC);
        end
        @(negedge clk);
        resetn    = 1'b1;
        drv_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pixel();
        cmd_t c;
        int   hold;
        c.raw = 1'b0; c.x = 8'h10; c.y = 8'h20; c.rgb = 16'hF800;
        drv_ready = 1'b1;
        drive_push(c);
        @(negedge clk);
        push = 1'b0;
        n_tests++;
        if (strobe !== 1'b0 || level !== LW'(1)) begin
            n_fail++;
            $display("FAIL pixel_cycle1: strobe %b level %0d want 0/1", strobe, level);
        end
        @(negedge clk);
        n_tests++;
        if (strobe !== 1'b1 || busy !== 1'b1 || level !== LW'(0)) begin
            n_fail++;
            $display("FAIL pixel_strobe: strobe %b busy %b level %0d want 1/1/0", strobe, busy, level);
        end
        n_tests++;
        if ({setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
            n_fail++;
            $display("FAIL pixel_fields: got %h want %h", {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
        end
        drv_ready = 1'b0;
        hold = $urandom_range(2, 6);
        repeat (hold) begin
            @(negedge clk);
            n_tests++;
            if (strobe !== 1'b0 || {setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
                n_fail++;
                $display("FAIL pixel_hold: strobe %b fields %h want 0 %h", strobe,
                         {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
            end
        end
        drv_valid = 1'b1;
        drv_ready = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || level !== LW'(0) || empty !== 1'b1 ||
            {setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
            n_fail++;
            $display("FAIL pixel_done: busy %b level %0d empty %b fields %h want 0/0/1 %h",
                     busy, level, empty, {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
        end
    endtask

    task automatic test_raw();
        cmd_t c;
        int   hold;
        c.raw = 1'b1; c.x = 8'h01; c.y = 8'hA5; c.rgb = 16'($urandom);
        drv_ready = 1'b1;
        drive_push(c);
        @(negedge clk);
        push = 1'b0;
        @(negedge clk);
        n_tests++;
        if (strobe !== 1'b1 || setpixel_raw8tx !== 1'b0 || x_dc !== 8'h01 || y_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL raw_strobe: strobe %b sp %b x %h y %h want 1 0 01 a5",
                     strobe, setpixel_raw8tx, x_dc, y_data);
        end
        drv_ready = 1'b0;
        hold = $urandom_range(1, 5);
        repeat (hold) begin
            @(negedge clk);
            n_tests++;
            if (setpixel_raw8tx !== 1'b0 || y_data !== 8'hA5 || x_dc !== 8'h01) begin
                n_fail++;
                $display("FAIL raw_hold: sp %b x %h y %h want 0 01 a5", setpixel_raw8tx, x_dc, y_data);
            end
        end
        drv_valid = 1'b1;
        drv_ready = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || y_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL raw_done: busy %b y %h want 0 a5", busy, y_data);
        end
    endtask

    task automatic test_order();
        cmd_t c;
        int   waited, hold, delay, low_cnt;
        drv_ready = 1'b0;
        model_q.delete();
        for (int i = 0; i < 5; i++) begin
            c = rand_cmd();
            drive_push(c);
            model_q.push_back(c);
            @(negedge clk);
        end
        push = 1'b0;
        n_tests++;
        if (level !== LW'(5)) begin
            n_fail++;
            $display("FAIL order_level: got %0d want 5", level);
        end
        drv_ready = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            waited = 0;
            while (strobe !== 1'b1 && waited < 20) begin
                low_cnt++;
                @(negedge clk);
                waited++;
            end
            n_tests++;
            if (strobe !== 1'b1) begin
                n_fail++;
                $display("FAIL order_strobe[%0d]: no strobe within 20 cycles", i);
            end
            if (i > 0) begin
                n_tests++;
                if (low_cnt < 1) begin
                    n_fail++;
                    $display("FAIL order_gap[%0d]: got %0d low cycles want >=1", i, low_cnt);
                end
            end
            c = model_q.pop_front();
            n_tests++;
            if ({setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
                n_fail++;
                $display("FAIL order_fields[%0d]: got %h want %h", i,
                         {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
            end
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge clk);
                n_tests++;
                if (strobe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL order_strobe_hold[%0d]: got %b want 1", i, strobe);
                end
            end
            drv_ready = 1'b0;
            low_cnt   = 0;
            delay = $urandom_range(1, 4);
            repeat (delay) begin
                @(negedge clk);
                if (strobe === 1'b0) low_cnt++;
                n_tests++;
                if ({setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
                    n_fail++;
                    $display("FAIL order_stable[%0d]: got %h want %h", i,
                             {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
                end
            end
            drv_valid = 1'b1;
            drv_ready = 1'b1;
            @(negedge clk);
            drv_valid = 1'b0;
            if (strobe === 1'b0) low_cnt++;
            n_tests++;
            if ({setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
                n_fail++;
                $display("FAIL order_after_valid[%0d]: got %h want %h", i,
                         {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
            end
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL order_drained: busy %b empty %b want 0 1", busy, empty);
        end
    endtask

    task automatic test_push_pop();
        cmd_t c;
        int   waited;
        drv_ready = 1'b0;
        model_q.delete();
        for (int i = 0; i < 3; i++) begin
            c = rand_cmd();
            drive_push(c);
            model_q.push_back(c);
            if (i == 2) drv_ready = 1'b1;
            @(negedge clk);
        end
        push = 1'b0;
        n_tests++;
        if (level !== LW'(2) || strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop_level: level %0d strobe %b want 2 1", level, strobe);
        end
        for (int i = 0; i < 3; i++) begin
            waited = 0;
            while (strobe !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            c = model_q.pop_front();
            n_tests++;
            if (strobe !== 1'b1 || {setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
                n_fail++;
                $display("FAIL pushpop_drain[%0d]: strobe %b fields %h want 1 %h", i, strobe,
                         {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
            end
            drv_ready = 1'b0;
            @(negedge clk);
            drv_valid = 1'b1;
            drv_ready = 1'b1;
            @(negedge clk);
            drv_valid = 1'b0;
        end
    endtask

    task automatic test_overflow();
        cmd_t c;
        int   waited;
        drv_ready = 1'b0;
        model_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            c = rand_cmd();
            if (i == DEPTH) begin
                n_tests++;
                if (overflow !== 1'b0 || full !== 1'b1 || level !== LW'(DEPTH)) begin
                    n_fail++;
                    $display("FAIL ovf_at_full: ovf %b full %b level %0d want 0 1 %0d",
                             overflow, full, level, DEPTH);
                end
            end
            drive_push(c);
            if (i < DEPTH) model_q.push_back(c);
            @(negedge clk);
        end
        push = 1'b0;
        n_tests++;
        if (level !== LW'(DEPTH) || full !== 1'b1 || empty !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: level %0d full %b empty %b ovf %b want %0d 1 0 1",
                     level, full, empty, overflow, DEPTH);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        drive_push(rand_cmd());
        clr_err = 1'b1;
        @(negedge clk);
        push    = 1'b0;
        clr_err = 1'b0;
        n_tests++;
        if (overflow !== 1'b1 || level !== LW'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_clr_vs_event: ovf %b level %0d want 1 %0d", overflow, level, DEPTH);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        drive_push(rand_cmd());
        drv_ready = 1'b1;
        @(negedge clk);
        push = 1'b0;
        n_tests++;
        if (level !== LW'(DEPTH - 1) || overflow !== 1'b1 || strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_push_pop_full: level %0d ovf %b strobe %b want %0d 1 1",
                     level, overflow, strobe, DEPTH - 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            waited = 0;
            while (strobe !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            c = model_q.pop_front();
            n_tests++;
            if (strobe !== 1'b1 || {setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(c)) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: strobe %b fields %h want 1 %h", i, strobe,
                         {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(c));
            end
            drv_ready = 1'b0;
            @(negedge clk);
            drv_valid = 1'b1;
            drv_ready = 1'b1;
            @(negedge clk);
            drv_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (empty !== 1'b1 || busy !== 1'b0 || level !== LW'(0) || strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_final: empty %b busy %b level %0d strobe %b want 1 0 0 0",
                     empty, busy, level, strobe);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

`ifdef OLED_PIXEL_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        cmd_t a, b;
        int   waited;
        drv_ready = 1'b0;
        a = rand_cmd();
        b = rand_cmd();
        drive_push(a);
        @(negedge clk);
        drive_push(b);
        @(negedge clk);
        push      = 1'b0;
        drv_ready = 1'b1;
        waited = 0;
        while (strobe !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (strobe !== 1'b1 || {setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(a)) begin
            n_fail++;
            $display("FAIL tmo_first: strobe %b fields %h want 1 %h", strobe,
                     {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(a));
        end
        drv_ready = 1'b0;
        for (int k = 1; k <= int'(TMO) + 1; k++) begin
            @(negedge clk);
            if (k == 3) drv_ready = 1'b1;
            if (k == int'(TMO) - 1) begin
                n_tests++;
                if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tmo_early: err %b busy %b want 0 1", timeout_err, busy);
                end
            end
            if (k == int'(TMO)) begin
                n_tests++;
                if (timeout_err !== 1'b1 || strobe !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tmo_fire: err %b strobe %b busy %b want 1 0 0",
                             timeout_err, strobe, busy);
                end
            end
            if (k == int'(TMO) + 1) begin
                n_tests++;
                if (strobe !== 1'b1 || {setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(b)) begin
                    n_fail++;
                    $display("FAIL tmo_next: strobe %b fields %h want 1 %h", strobe,
                             {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(b));
                end
            end
        end
        drv_ready = 1'b0;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_ready = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_sticky: busy %b err %b want 0 1", busy, timeout_err);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: got %b want 0", timeout_err);
        end
    endtask
`else
    task automatic test_timeout();
        cmd_t a;
        int   waited;
        a = rand_cmd();
        drv_ready = 1'b1;
        drive_push(a);
        @(negedge clk);
        push = 1'b0;
        waited = 0;
        while (strobe !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        drv_ready = 1'b0;
        repeat (3 * TMO) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || timeout_err !== 1'b0 || strobe !== 1'b0 ||
            {setpixel_raw8tx, x_dc, y_data, rgb} !== expect_out(a)) begin
            n_fail++;
            $display("FAIL notmo_wait: busy %b err %b strobe %b fields %h want 1 0 0 %h",
                     busy, timeout_err, strobe, {setpixel_raw8tx, x_dc, y_data, rgb}, expect_out(a));
        end
        drv_valid = 1'b1;
        drv_ready = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL notmo_done: busy %b want 0", busy);
        end
    endtask
`endif

    task automatic test_reset_midwait();
        int waited;
        drv_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(rand_cmd());
            @(negedge clk);
        end
        push      = 1'b0;
        drv_ready = 1'b1;
        waited = 0;
        while (strobe !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        drv_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (level !== LW'(3) || busy !== 1'b1 || strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_pre: level %0d busy %b strobe %b want 3 1 0", level, busy, strobe);
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({empty, full, level, busy, strobe, setpixel_raw8tx, x_dc, y_data, rgb,
             overflow, timeout_err} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL midwait_reset: got %h want %h",
                     {empty, full, level, busy, strobe, setpixel_raw8tx, x_dc, y_data, rgb,
                      overflow, timeout_err}, RESET_VEC);
        end
        @(negedge clk);
        resetn    = 1'b1;
        drv_valid = 1'b1;
        @(negedge clk);
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({empty, full, level, busy, strobe, setpixel_raw8tx, x_dc, y_data, rgb,
             overflow, timeout_err} !== RESET_VEC) begin
            n_fail++;
            $display("FAIL midwait_late_valid: got %h want %h",
                     {empty, full, level, busy, strobe, setpixel_raw8tx, x_dc, y_data, rgb,
                      overflow, timeout_err}, RESET_VEC);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        push        = 1'b0;
        push_raw    = 1'b0;
        push_x_dc   = '0;
        push_y_data = '0;
        push_rgb    = '0;
        clr_err     = 1'b0;
        drv_ready   = 1'b0;
        drv_valid   = 1'b0;
        test_reset();
        test_pixel();
        test_raw();
        test_order();
        test_push_pop();
        test_overflow();
        test_timeout();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
